// File: rtl/commit_unit_pkg.sv
// Shared types for the commit stage: ROB head entry layout,
// instruction-type encodings and the commit FSM state enum.
package commit_unit_pkg;

    localparam int CU_XLEN  = 32;
    localparam int CU_TAG_W = 4;

    // itype encodings; any itype with bit 1 set writes a register
    localparam logic [1:0] ITYPE_BRANCH = 2'b00;
    localparam logic [1:0] ITYPE_STORE  = 2'b01;

    typedef struct packed {
        logic [CU_TAG_W-1:0] ROB_number;
        logic [1:0]          itype;
        logic [4:0]          dest;
        logic [CU_XLEN-1:0]  value;
        logic                branch_result;
        logic [CU_XLEN-1:0]  target_pc;
    } ROB_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        STORE_WAIT,
        FLUSH
    } commit_state_t;

    function automatic logic is_reg_type(input logic [1:0] itype);
        return itype[1];
    endfunction

endpackage

// File: rtl/commit_unit.sv
// In-order retirement controller: dequeues the ROB head, writes the
// register file, handshakes stores and raises flush on mispredicts.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int XLEN  = CU_XLEN,
    parameter int TAG_W = CU_TAG_W,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  ROB_entry_t       head,
    input  logic             head_ready,
    input  logic             rob_empty,
    input  logic             head_store,
    output logic             rd_en,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [TAG_W-1:0] rf_wtag,
    output logic             st_req,
    output logic [TAG_W-1:0] st_tag,
    input  logic             st_ack,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] retired
);

    commit_state_t state;
    commit_state_t state_next;
    logic          start_store;
    logic          start_flush;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and Mealy commit outputs
    always_comb begin
        state_next  = state;
        rd_en       = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        rf_wtag     = '0;
        start_store = 1'b0;
        start_flush = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rob_empty && head_ready) begin
                    unique case (1'b1)
                        is_reg_type(head.itype): begin
                            rd_en    = 1'b1;
                            rf_we    = (head.dest != 5'd0);
                            rf_waddr = head.dest;
                            rf_wdata = head.value;
                            rf_wtag  = head.ROB_number;
                        end
                        head_store: begin
                            start_store = 1'b1;
                            state_next  = STORE_WAIT;
                        end
                        (head.itype == ITYPE_BRANCH): begin
                            rd_en = 1'b1;
                            if (head.branch_result) begin
                                start_flush = 1'b1;
                                state_next  = FLUSH;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            STORE_WAIT: begin
                if (st_ack) begin
                    rd_en      = 1'b1;
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // a reset cycle must never dequeue or start a side effect
        if (reset) begin
            state_next  = IDLE;
            rd_en       = 1'b0;
            rf_we       = 1'b0;
            rf_waddr    = '0;
            rf_wdata    = '0;
            rf_wtag     = '0;
            start_store = 1'b0;
            start_flush = 1'b0;
        end
    end

    assign st_req = (state == STORE_WAIT);
    assign flush  = (state == FLUSH);

    // Capture the store tag on entry and hold it through the handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            st_tag <= '0;
        end else if (start_store) begin
            st_tag <= head.ROB_number;
        end else if (state_next != STORE_WAIT) begin
            st_tag <= '0;
        end
    end

    // Capture the redirect target for the single flush cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_pc <= '0;
        end else if (start_flush) begin
            redirect_pc <= head.target_pc;
        end else begin
            redirect_pc <= '0;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (rd_en) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: doc/commit_unit.md
# commit_unit

In-order retirement controller for the reorder buffer. It watches the ROB head and dequeues it when ready, at most one instruction per cycle. On dequeue it writes the architectural register file, performs a handshake with the store path for stores, and raises a pipeline flush with a PC redirect on a mispredicted branch. It sits between the ROB, the register file / register status table, the data-memory store port, and fetch.

## Interface
Parameters:
- XLEN, 32, data width
- TAG_W, 4, ROB tag width; tag 0 is reserved as "no tag"
- CNT_W, 32, retired-instruction counter width

Ports (clock and reset first):
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- head  in  ROB_entry_t  ROB head entry, read combinationally; uses fields ROB_number, itype, dest, value, branch_result, target_pc
- head_ready  in  1  head result is valid
- rob_empty  in  1  ROB is empty
- head_store  in  1  head itype is 2'b01
- rd_en  out  1  dequeue the head this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  destination architectural register
- rf_wdata  out  XLEN  value to write
- rf_wtag  out  TAG_W  committing ROB tag; the status table clears the register's tag only if it matches
- st_req  out  1  store request to data memory
- st_tag  out  TAG_W  ROB tag of the store being performed
- st_ack  in  1  store accepted by memory
- flush  out  1  one-cycle pipeline flush pulse
- redirect_pc  out  XLEN  correct PC; valid while flush=1
- retired  out  CNT_W  count of committed instructions

## Operation
States: IDLE, STORE_WAIT, FLUSH.

IDLE:
- No commit when rob_empty=1 or head_ready=0. All outputs are 0.
- Register-destination or load head (itype[1]=1): assert rd_en and rf_we. Drive rf_waddr=head.dest, rf_wdata=head.value, rf_wtag=head.ROB_number.
- If head.dest==0, hold rf_we=0 but still assert rd_en.
- Store head (itype=01): do not dequeue. Next state is STORE_WAIT; st_req and st_tag=head.ROB_number are registered.
- Branch head (itype=00) with branch_result=0 (correctly predicted): assert rd_en only.
- Branch head with branch_result=1 (mispredicted): assert rd_en. Next state is FLUSH; flush and redirect_pc=head.target_pc are registered.

STORE_WAIT:
- Hold st_req=1 and a stable st_tag until st_ack is sampled high.
- In the st_ack cycle: assert rd_en, deassert st_req next cycle, return to IDLE.
- No other commit happens while in STORE_WAIT.

FLUSH:
- Lasts exactly one cycle with flush=1. No commit in this cycle, even if head_ready=1. Return to IDLE.

Counter:
- retired increments by 1 on every cycle with rd_en=1. It wraps modulo 2^CNT_W.

## Timing
- Reset values: state=IDLE; rd_en, rf_we, st_req, flush = 0; rf_waddr, rf_wdata, rf_wtag, st_tag, redirect_pc, retired = 0.
- rd_en, rf_we, rf_waddr, rf_wdata and rf_wtag are combinational (Mealy) in IDLE. A ready head commits in the same cycle, and the ROB advances rptr on the next edge. Throughput is 1 per cycle.
- st_req rises 1 cycle after the store head becomes ready, and stays high through the st_ack cycle.
- Minimum store latency is 2 cycles when st_ack is already high on the first st_req cycle.
- flush rises the cycle after the mispredicted branch's rd_en and is high for exactly 1 cycle.
- Simultaneous events:
  - st_ack while in IDLE is ignored.
  - A flush cycle with the ROB non-empty is ignored; the ROB is cleared externally by flush.
  - head_ready dropping while in STORE_WAIT does not abort the store.
- Reset mid-STORE_WAIT or mid-FLUSH: the next cycle is IDLE with st_req=0 and flush=0. No rd_en is issued.
- Tag wrap: tags run 1..2^TAG_W-1. rf_wtag never equals 0 while rf_we=1.

## Structure
- ROB_entry_t, the itype encodings (BRANCH=2'b00, STORE=2'b01, REG=2'b1x) and the commit state enum belong in the shared structs header.
- The block is a single module with no sub-modules. The FSM, output mux and counter fit well under 200 lines.

## Test plan
- ALU head {itype=10, dest=5, value=0xDEADBEEF, tag=3, ready}: same cycle rd_en=1, rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rf_wtag=3; retired goes 0→1.
- Three ready ALU heads in consecutive cycles: rd_en high for 3 consecutive cycles, retired=3. A head with dest=0 gives rd_en=1, rf_we=0.
- Store head tag=7, st_ack held low for 3 cycles, then high: st_req=1 with st_tag=7 for 4 cycles; rd_en=1 only in the ack cycle; state returns to IDLE.
- Mispredicted branch, target_pc=0x0000_0400: rd_en=1 in cycle N; flush=1 and redirect_pc=0x400 in cycle N+1 only; no rd_en in N+1 even with a ready head.
- reset asserted during STORE_WAIT: next cycle st_req=0, state IDLE, retired=0. A ready store head afterwards restarts the handshake.
- rob_empty=1 with head_ready=1 (stale head data): rd_en=0, rf_we=0, st_req=0 for all cycles.
